fft_peak_detector: RTL and testbench

Streaming reader for the FFT output port. It consumes one frame of N_POINTS complex bins from `fft_radix2_dit` (`data_out_real`/`data_out_imag`/`data_out_valid`) and computes |X[k]|² per bin. It tracks the largest magnitude over bins 0..N_POINTS/2-1 and reports the peak bin index and magnitude once per frame. This replaces the testbench-side peak search with synthesizable logic for on-chip tone detection.

---
 rtl/fft_pkg.sv | 14 +
 rtl/fft_mag_sq.sv | 72 +++++++
 rtl/fft_peak_detector.sv | 159 +++++++++++++++
 tb/tb_fft_peak_detector.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default geometry, bin index width and control-state encoding.
package fft_pkg;

  localparam int unsigned DEF_N_POINTS   = 64;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned BIN_W          = $clog2(DEF_N_POINTS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2
  } fft_state_e;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage pipelined re^2+im^2 with valid/tag passthrough; flush drops everything in flight.
module fft_mag_sq #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAG_W      = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  in_re,
  input  logic signed [DATA_WIDTH-1:0]  in_im,
  input  logic        [TAG_W-1:0]       in_tag,
  output logic                          out_valid,
  output logic        [TAG_W-1:0]       out_tag,
  output logic        [2*DATA_WIDTH-1:0] out_mag
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] re_ext, im_ext;
  logic signed [PW-1:0] prod_re_q, prod_re_d, prod_im_q, prod_im_d;
  logic                 v1_q, v1_d, v2_q, v2_d;
  logic [TAG_W-1:0]     tag1_q, tag1_d, tag2_q, tag2_d;
  logic [PW-1:0]        mag_q, mag_d;

  // Squares are non-negative and at most 2^(PW-2), so the unsigned sum cannot wrap.
  always_comb begin
    re_ext    = PW'(in_re);
    im_ext    = PW'(in_im);
    prod_re_d = prod_re_q;
    prod_im_d = prod_im_q;
    tag1_d    = tag1_q;
    v1_d      = flush ? 1'b0 : in_valid;
    if (in_valid) begin
      prod_re_d = re_ext * re_ext;
      prod_im_d = im_ext * im_ext;
      tag1_d    = in_tag;
    end
    mag_d  = mag_q;
    tag2_d = tag2_q;
    v2_d   = flush ? 1'b0 : v1_q;
    if (v1_q) begin
      mag_d  = $unsigned(prod_re_q) + $unsigned(prod_im_q);
      tag2_d = tag1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_re_q <= '0;
      prod_im_q <= '0;
      v1_q      <= 1'b0;
      tag1_q    <= '0;
      mag_q     <= '0;
      v2_q      <= 1'b0;
      tag2_q    <= '0;
    end else begin
      prod_re_q <= prod_re_d;
      prod_im_q <= prod_im_d;
      v1_q      <= v1_d;
      tag1_q    <= tag1_d;
      mag_q     <= mag_d;
      v2_q      <= v2_d;
      tag2_q    <= tag2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_tag   = tag2_q;
  assign out_mag   = mag_q;

endmodule

// File: rtl/fft_peak_detector.sv
// Streams one FFT frame, tracks the strongest bin in the search window and reports it once per frame.
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS    = DEF_N_POINTS,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned SEARCH_BINS = N_POINTS / 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic signed [DATA_WIDTH-1:0]  data_in_real,
  input  logic signed [DATA_WIDTH-1:0]  data_in_imag,
  input  logic                          data_valid,
  output logic [$clog2(N_POINTS)-1:0]   peak_bin,
  output logic [2*DATA_WIDTH-1:0]       peak_mag,
  output logic                          peak_valid,
  output logic                          busy,
  output logic                          stray
);

  localparam int unsigned CNT_W = $clog2(N_POINTS);
  localparam int unsigned MAG_W = 2 * DATA_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] S_COLLECT = 2'(ST_COLLECT);
  localparam logic [1:0] S_DRAIN   = 2'(ST_DRAIN);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain_q, drain_d;
  logic [CNT_W-1:0] best_bin_q, best_bin_d;
  logic [MAG_W-1:0] best_mag_q, best_mag_d;
  logic [CNT_W-1:0] peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0] peak_mag_q, peak_mag_d;
  logic             peak_valid_q, peak_valid_d;
  logic             busy_q, busy_d;
  logic             stray_q, stray_d;
  logic             accept_c;

  logic             mag_valid;
  logic [CNT_W-1:0] mag_tag;
  logic [MAG_W-1:0] mag_val;

  fft_mag_sq #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_W      (CNT_W)
  ) u_mag_sq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start),
    .in_valid  (accept_c),
    .in_re     (data_in_real),
    .in_im     (data_in_imag),
    .in_tag    (cnt_q),
    .out_valid (mag_valid),
    .out_tag   (mag_tag),
    .out_mag   (mag_val)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    best_bin_d   = best_bin_q;
    best_mag_d   = best_mag_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    peak_valid_d = 1'b0;
    stray_d      = stray_q;
    accept_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
        end
      end
      S_COLLECT: begin
        if (start) begin
          cnt_d = '0;
        end else if (data_valid) begin
          accept_c = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(N_POINTS - 1)) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = '0;
        end else if (drain_q) begin
          state_d = S_IDLE;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      stray_d = 1'b0;
    end else if (state_q == S_IDLE && data_valid) begin
      stray_d = 1'b1;
    end

    // Bin 0 seeds the search; later in-window bins win only when strictly larger.
    if (mag_valid && !start) begin
      if (mag_tag == '0 || (32'(mag_tag) < SEARCH_BINS && mag_val > best_mag_q)) begin
        best_bin_d = mag_tag;
        best_mag_d = mag_val;
      end
      if (mag_tag == CNT_W'(N_POINTS - 1)) begin
        peak_bin_d   = best_bin_d;
        peak_mag_d   = best_mag_d;
        peak_valid_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      best_bin_q   <= '0;
      best_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      best_bin_q   <= best_bin_d;
      best_mag_q   <= best_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      peak_valid_q <= peak_valid_d;
      busy_q       <= busy_d;
      stray_q      <= stray_d;
    end
  end

  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign peak_valid = peak_valid_q;
  assign busy       = busy_q;
  assign stray      = stray_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Self-checking bench for fft_peak_detector: directed vector table, corner sequences and random frames.
module tb_fft_peak_detector;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int SB = N / 2;
  localparam int BW = 6;

  typedef struct {
    int     b0;
    int     r0;
    int     i0;
    int     b1;
    int     r1;
    int     i1;
    int     gap;
    int     exp_bin;
    longint exp_mag;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] re_in;
  logic [DW-1:0] im_in;
  logic          data_valid;
  logic [BW-1:0] peak_bin;
  logic [2*DW-1:0] peak_mag;
  logic          peak_valid;
  logic          busy;
  logic          stray;

  int n_checks;
  int n_fail;
  int fr_re[N];
  int fr_im[N];
  vec_t vecs[5];

  fft_peak_detector #(
    .N_POINTS    (N),
    .DATA_WIDTH  (DW),
    .SEARCH_BINS (SB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .data_in_real (re_in),
    .data_in_imag (im_in),
    .data_valid   (data_valid),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .peak_valid   (peak_valid),
    .busy         (busy),
    .stray        (stray)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_frame();
    for (int k = 0; k < N; k++) begin
      fr_re[k] = 0;
      fr_im[k] = 0;
    end
  endtask

  // Reference: brute-force max over the search window, lowest index on ties.
  task automatic model(output int eb, output longint em);
    longint m;
    eb = 0;
    em = longint'(fr_re[0]) * fr_re[0] + longint'(fr_im[0]) * fr_im[0];
    for (int k = 1; k < SB; k++) begin
      m = longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
      if (m > em) begin
        em = m;
        eb = k;
      end
    end
  endtask

  // Called on a negedge; start goes high immediately (may coincide with a previous peak_valid cycle).
  task automatic run_frame(input int gap, input int exp_bin, input longint exp_mag, input string nm);
    int early;
    int g;
    early = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_up"}, longint'(busy), 1);
    check({nm, "_stray_clr"}, longint'(stray), 0);
    check({nm, "_pulse_width"}, longint'(peak_valid), 0);
    for (int k = 0; k < N; k++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
      repeat (g) begin
        data_valid = 1'b0;
        re_in = 16'($urandom);
        im_in = 16'($urandom);
        @(negedge clk);
        if (peak_valid) early++;
      end
      data_valid = 1'b1;
      re_in = 16'(fr_re[k]);
      im_in = 16'(fr_im[k]);
      @(negedge clk);
      if (peak_valid) early++;
    end
    data_valid = 1'b0;
    @(negedge clk);
    if (peak_valid) early++;
    check({nm, "_busy_drain"}, longint'(busy), 1);
    check({nm, "_no_early_pulse"}, longint'(early), 0);
    @(negedge clk);
    check({nm, "_peak_valid"}, longint'(peak_valid), 1);
    check({nm, "_busy_fall"}, longint'(busy), 0);
    check({nm, "_peak_bin"}, longint'(peak_bin), longint'(exp_bin));
    check({nm, "_peak_mag"}, longint'(peak_mag), exp_mag);
  endtask

  initial begin
    int     eb;
    longint em;
    int     cnt;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    data_valid = 1'b0;
    re_in = '0;
    im_in = '0;

    vecs[0] = '{b0: 4, r0: 16383, i0: 0, b1: -1, r1: 0, i1: 0, gap: 0,
                exp_bin: 4, exp_mag: 64'd268402689};
    vecs[1] = '{b0: 3, r0: 1000, i0: -1000, b1: 7, r1: 1000, i1: -1000, gap: 0,
                exp_bin: 3, exp_mag: 64'd2000000};
    vecs[2] = '{b0: 40, r0: 20000, i0: 0, b1: 9, r1: 100, i1: 0, gap: 0,
                exp_bin: 9, exp_mag: 64'd10000};
    vecs[3] = '{b0: 5, r0: -32768, i0: -32768, b1: -1, r1: 0, i1: 0, gap: 0,
                exp_bin: 5, exp_mag: 64'd2147483648};
    vecs[4] = '{b0: 4, r0: 16383, i0: 0, b1: -1, r1: 0, i1: 0, gap: 1,
                exp_bin: 4, exp_mag: 64'd268402689};

    repeat (2) @(negedge clk);
    check("rst_peak_bin", longint'(peak_bin), 0);
    check("rst_peak_mag", longint'(peak_mag), 0);
    check("rst_peak_valid", longint'(peak_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_stray", longint'(stray), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Stray data while idle.
    for (int p = 0; p < 3; p++) begin
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      @(negedge clk);
    end
    check("stray_set", longint'(stray), 1);
    check("stray_idle_busy", longint'(busy), 0);

    // Directed table; vecs[0] also clears stray via its start.
    foreach (vecs[v]) begin
      clear_frame();
      fr_re[vecs[v].b0] = vecs[v].r0;
      fr_im[vecs[v].b0] = vecs[v].i0;
      if (vecs[v].b1 >= 0) begin
        fr_re[vecs[v].b1] = vecs[v].r1;
        fr_im[vecs[v].b1] = vecs[v].i1;
      end
      run_frame(vecs[v].gap, vecs[v].exp_bin, vecs[v].exp_mag, $sformatf("vec%0d", v));
    end

    // Abort after 20 bins, then a complete frame peaking at bin 12.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      data_valid = 1'b1;
      re_in = 16'(20000);
      im_in = 16'(0);
      @(negedge clk);
    end
    data_valid = 1'b0;
    clear_frame();
    fr_re[12] = 500;
    fr_im[12] = -7;
    run_frame(0, 12, 64'd250049, "restart");

    // Restart while draining: the finished frame must not report.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      data_valid = 1'b1;
      re_in = 16'(k == 2 ? 3000 : 1);
      im_in = 16'(0);
      @(negedge clk);
    end
    data_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    repeat (5) begin
      if (peak_valid) cnt++;
      @(negedge clk);
    end
    check("drain_abort_no_pulse", longint'(cnt), 0);
    check("drain_abort_busy", longint'(busy), 1);
    check("drain_abort_old_mag", longint'(peak_mag), 64'd250049);

    // Random frames; every other one uses small values to provoke ties.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        if (r % 2 == 0) begin
          fr_re[k] = int'($signed(16'($urandom)));
          fr_im[k] = int'($signed(16'($urandom)));
        end else begin
          fr_re[k] = int'($urandom_range(6, 0)) - 3;
          fr_im[k] = int'($urandom_range(6, 0)) - 3;
        end
      end
      model(eb, em);
      run_frame((r < 3) ? 0 : -1, eb, em, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      data_valid = 1'b1;
      re_in = 16'(12345);
      im_in = 16'(-321);
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_peak_bin", longint'(peak_bin), 0);
    check("arst_peak_mag", longint'(peak_mag), 0);
    check("arst_peak_valid", longint'(peak_valid), 0);
    check("arst_busy", longint'(busy), 0);
    check("arst_stray", longint'(stray), 0);
    @(negedge clk);
    data_valid = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (peak_valid) cnt++;
    end
    check("arst_no_pulse", longint'(cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
